// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default geometry, data width, FSM states.
// Used by icache and icache_line_ram.
package icache_pkg;

   localparam int ICACHE_INDEX_WIDTH = 8;
   localparam int ICACHE_ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH         = 32;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } icache_state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Tag/valid/data storage for the direct-mapped icache.
// One combinational read port and one synchronous write port.
module icache_line_ram
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
   parameter int TAG_WIDTH   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic                   rd_valid,
   output logic [TAG_WIDTH-1:0]   rd_tag,
   output logic [DATA_WIDTH-1:0]  rd_data,
   input  logic                   we,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [TAG_WIDTH-1:0]   wr_tag,
   input  logic [DATA_WIDTH-1:0]  wr_data
);

   localparam int LINES = 1 << INDEX_WIDTH;

   logic [LINES-1:0]      valid;
   logic [TAG_WIDTH-1:0]  tags [LINES];
   logic [DATA_WIDTH-1:0] data [LINES];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[rd_index];

   // Only the valid bits need reset; tag/data are qualified by them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid <= '0;
      else if (we)
         valid[wr_index] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-outstanding refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
   parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  in_fetcher_ce,
   input  logic [ADDR_WIDTH-1:0] in_fetcher_addr,
   output logic                  out_fetcher_ce,
   output logic [DATA_WIDTH-1:0] out_fetcher_instr,
   output logic                  out_mem_ce,
   output logic [ADDR_WIDTH-1:0] out_mem_addr,
   input  logic                  in_mem_ce,
   input  logic [DATA_WIDTH-1:0] in_mem_data,
   input  logic                  in_rob_misbranch
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           out_hit_count,
   output logic [31:0]           out_miss_count
`endif
);

   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

   icache_state_t          state;
   logic                   rd_valid;
   logic [TAG_WIDTH-1:0]   rd_tag;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   hit, accept, fill;
   logic                   unused_bits;

   assign unused_bits = ^in_fetcher_addr[1:0];

   // A request is taken only if no response went out last cycle, so the
   // fetcher (which may still be holding its request) never sees back-to-back pulses.
   assign accept = rdy && state == IDLE && in_fetcher_ce && !in_rob_misbranch && !out_fetcher_ce;
   assign hit    = rd_valid && rd_tag == in_fetcher_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign fill   = rdy && state == MISS && in_mem_ce && !in_rob_misbranch;

   icache_line_ram #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .rd_index(in_fetcher_addr[INDEX_WIDTH+1:2]),
      .rd_valid(rd_valid),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .we      (fill),
      .wr_index(out_mem_addr[INDEX_WIDTH+1:2]),
      .wr_tag  (out_mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]),
      .wr_data (in_mem_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         out_fetcher_ce    <= 1'b0;
         out_fetcher_instr <= '0;
         out_mem_ce        <= 1'b0;
         out_mem_addr      <= '0;
      end else if (rdy) begin
         out_fetcher_ce <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     out_fetcher_ce    <= 1'b1;
                     out_fetcher_instr <= rd_data;
                  end else begin
                     state        <= MISS;
                     out_mem_ce   <= 1'b1;
                     out_mem_addr <= {in_fetcher_addr[ADDR_WIDTH-1:2], 2'b00};
                  end
               end
            end
            MISS: begin
               // Misbranch wins over a same-cycle ack: abandon without filling.
               if (in_rob_misbranch) begin
                  state      <= IDLE;
                  out_mem_ce <= 1'b0;
               end else if (in_mem_ce) begin
                  state             <= IDLE;
                  out_mem_ce        <= 1'b0;
                  out_fetcher_ce    <= 1'b1;
                  out_fetcher_instr <= in_mem_data;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_hit_count  <= '0;
         out_miss_count <= '0;
      end else if (accept) begin
         if (hit) out_hit_count  <= sat_inc(out_hit_count);
         else     out_miss_count <= sat_inc(out_miss_count);
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed test of icache: cold miss, hit, conflict, aborts, rdy stall, reset mid-miss.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst, rdy, fce_in, mem_ce_in, misb;
   logic [31:0] addr, mem_data;
   logic        fce, mce;
   logic [31:0] instr, maddr;
   int          checks = 0;
   int          failures = 0;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   icache dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .in_fetcher_ce    (fce_in),
      .in_fetcher_addr  (addr),
      .out_fetcher_ce   (fce),
      .out_fetcher_instr(instr),
      .out_mem_ce       (mce),
      .out_mem_addr     (maddr),
      .in_mem_ce        (mem_ce_in),
      .in_mem_data      (mem_data),
      .in_rob_misbranch (misb)
`ifdef ICACHE_STATS_EN
      ,
      .out_hit_count    (hit_cnt),
      .out_miss_count   (miss_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; fce_in = 1'b0; mem_ce_in = 1'b0; misb = 1'b0;
      addr = 32'h0; mem_data = 32'h0;
      step(); step();
      chk("rst_fce", {31'd0, fce}, 32'd0);
      chk("rst_mce", {31'd0, mce}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_maddr", maddr, 32'h0);
      rst = 1'b0;
      step();

      // cold miss on 0x10 (low address bits ignored)
      fce_in = 1'b1; addr = 32'h0000_0013;
      step();
      chk("cold_mce", {31'd0, mce}, 32'd1);
      chk("cold_maddr", maddr, 32'h0000_0010);
      chk("cold_nofce", {31'd0, fce}, 32'd0);
      mem_ce_in = 1'b1; mem_data = 32'h00A0_0093;
      step();
      chk("cold_fce", {31'd0, fce}, 32'd1);
      chk("cold_instr", instr, 32'h00A0_0093);
      chk("cold_mce_drop", {31'd0, mce}, 32'd0);
      mem_ce_in = 1'b0; fce_in = 1'b0;
      step();
      chk("cold_pulse", {31'd0, fce}, 32'd0);

      // hit; fetcher keeps request up one extra cycle -> no second pulse
      fce_in = 1'b1; addr = 32'h0000_0010;
      step();
      chk("hit_fce", {31'd0, fce}, 32'd1);
      chk("hit_instr", instr, 32'h00A0_0093);
      chk("hit_nomce", {31'd0, mce}, 32'd0);
      step();
      chk("hit_no_b2b", {31'd0, fce}, 32'd0);
      fce_in = 1'b0;
      step();

      // conflict: 0x410 shares index 4 with 0x10
      fce_in = 1'b1; addr = 32'h0000_0410;
      step();
      chk("conf_mce", {31'd0, mce}, 32'd1);
      chk("conf_maddr", maddr, 32'h0000_0410);
      mem_ce_in = 1'b1; mem_data = 32'h1234_5678;
      step();
      chk("conf_instr", instr, 32'h1234_5678);
      mem_ce_in = 1'b0; fce_in = 1'b0;
      step();
      fce_in = 1'b1; addr = 32'h0000_0010;
      step();
      chk("conf_remiss", {31'd0, mce}, 32'd1);
      chk("conf_remiss_addr", maddr, 32'h0000_0010);
      mem_ce_in = 1'b1; mem_data = 32'h00A0_0093;
      step();
      chk("conf_refill", instr, 32'h00A0_0093);
      mem_ce_in = 1'b0; fce_in = 1'b0;
      step();
`ifdef ICACHE_STATS_EN
      chk("stat_hit", hit_cnt, 32'd1);
      chk("stat_miss", miss_cnt, 32'd3);
`endif

      // abort two cycles into a miss on 0x20
      fce_in = 1'b1; addr = 32'h0000_0020;
      step();
      chk("abort_mce", {31'd0, mce}, 32'd1);
      step();
      misb = 1'b1;
      step();
      chk("abort_mce_drop", {31'd0, mce}, 32'd0);
      chk("abort_nofce", {31'd0, fce}, 32'd0);
      misb = 1'b0; fce_in = 1'b0; mem_ce_in = 1'b1; mem_data = 32'hBAD0_BAD0;
      step();
      chk("late_ack_fce", {31'd0, fce}, 32'd0);
      chk("late_ack_mce", {31'd0, mce}, 32'd0);
      mem_ce_in = 1'b0;
      // misbranch must not have invalidated 0x10
      fce_in = 1'b1; addr = 32'h0000_0010;
      step();
      chk("keep_line", instr, 32'h00A0_0093);
      chk("keep_line_fce", {31'd0, fce}, 32'd1);
      fce_in = 1'b0;
      step();

      // re-request 0x20 misses; stall with rdy low while ack is present
      fce_in = 1'b1; addr = 32'h0000_0020;
      step();
      chk("abort_remiss", {31'd0, mce}, 32'd1);
      rdy = 1'b0; mem_ce_in = 1'b1; mem_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_mce", {31'd0, mce}, 32'd1);
         chk("stall_fce", {31'd0, fce}, 32'd0);
      end
      rdy = 1'b1;
      step();
      chk("stall_fill_fce", {31'd0, fce}, 32'd1);
      chk("stall_fill_instr", instr, 32'hDEAD_BEEF);
      chk("stall_fill_mce", {31'd0, mce}, 32'd0);
      mem_ce_in = 1'b0; fce_in = 1'b0;
      step();

      // same-cycle misbranch discards a hit request
      fce_in = 1'b1; misb = 1'b1;
      step();
      chk("idle_misb_fce", {31'd0, fce}, 32'd0);
      misb = 1'b0;
      step();
      chk("post_misb_hit", instr, 32'hDEAD_BEEF);
      chk("post_misb_fce", {31'd0, fce}, 32'd1);
      fce_in = 1'b0;
      step();

      // ack and misbranch together: abort, no fill
      fce_in = 1'b1; addr = 32'h0000_0030;
      step();
      fce_in = 1'b0; mem_ce_in = 1'b1; misb = 1'b1; mem_data = 32'h1111_1111;
      step();
      chk("both_mce", {31'd0, mce}, 32'd0);
      chk("both_fce", {31'd0, fce}, 32'd0);
      mem_ce_in = 1'b0; misb = 1'b0; fce_in = 1'b1;
      step();
      chk("both_nofill", {31'd0, mce}, 32'd1);
      mem_ce_in = 1'b1; mem_data = 32'h2222_2222;
      step();
      chk("both_refill", instr, 32'h2222_2222);
      mem_ce_in = 1'b0; fce_in = 1'b0;
      step();

      // reset mid-miss, then a stray ack
      fce_in = 1'b1; addr = 32'h0000_0040;
      step();
      fce_in = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_async_mce", {31'd0, mce}, 32'd0);
      step();
      rst = 1'b0; mem_ce_in = 1'b1; mem_data = 32'h3333_3333;
      step();
      chk("rst_late_fce", {31'd0, fce}, 32'd0);
      chk("rst_late_instr", instr, 32'h0);
      mem_ce_in = 1'b0; fce_in = 1'b1; addr = 32'h0000_0010;
      step();
      chk("rst_invalid", {31'd0, mce}, 32'd1);
      fce_in = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1);
   end

endmodule
